// File: rtl/xc_malu_ctrl_if.sv
// Core/datapath-facing bus of the MALU controller: request handshake,
// datapath next-state values, packed adder operands/results and state outputs.
interface xc_malu_ctrl_if #(
  parameter int unsigned CW = 6
) ();
  logic          valid;
  logic          flush;
  logic          pw_32;
  logic          pw_16;
  logic          pw_8;
  logic          pw_4;
  logic          pw_2;
  logic          dp_ready;
  logic [63:0]   n_acc;
  logic [31:0]   n_arg_0;
  logic [31:0]   n_arg_1;
  logic [31:0]   padd_lhs;
  logic [31:0]   padd_rhs;
  logic          padd_sub;
  logic          padd_cin;
  logic          padd_cen;
  logic [31:0]   padd_result;
  logic [31:0]   padd_cout;
  logic [CW-1:0] count;
  logic [63:0]   acc;
  logic [31:0]   arg_0;
  logic [31:0]   arg_1;
  logic          busy;
  logic          ready;

  modport master (
    output valid, flush, pw_32, pw_16, pw_8, pw_4, pw_2, dp_ready,
           n_acc, n_arg_0, n_arg_1, padd_lhs, padd_rhs, padd_sub, padd_cin, padd_cen,
    input  padd_result, padd_cout, count, acc, arg_0, arg_1, busy, ready
  );

  modport slave (
    input  valid, flush, pw_32, pw_16, pw_8, pw_4, pw_2, dp_ready,
           n_acc, n_arg_0, n_arg_1, padd_lhs, padd_rhs, padd_sub, padd_cin, padd_cen,
    output padd_result, padd_cout, count, acc, arg_0, arg_1, busy, ready
  );
endinterface

// File: rtl/xc_malu_ctrl.sv
// Multi-cycle MALU sequencer: owns count/acc/arg state, steps it from the
// datapath, drives ready, and hosts the shared 32-bit packed adder.
module xc_malu_ctrl #(
  parameter int unsigned CW = 6
) (
  input  logic          i_clock,
  input  logic          i_reset,
  xc_malu_ctrl_if.slave io_malu
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_count, w_count;
  logic [63:0]   r_acc, w_acc;
  logic [31:0]   r_arg_0, w_arg_0;
  logic [31:0]   r_arg_1, w_arg_1;
  logic          r_busy, w_busy;
  logic          r_ready, w_ready;

  logic [31:0]   w_bnd;
  logic [31:0]   w_rhs_e;
  logic [31:0]   w_sum;
  logic [31:0]   w_cout;
  logic          w_carry;
  logic          w_cin_bit;

  // Next-state and register update; flush overrides every state.
  always_comb begin
    w_state = r_state;
    w_count = r_count;
    w_acc   = r_acc;
    w_arg_0 = r_arg_0;
    w_arg_1 = r_arg_1;
    case (r_state)
      ST_IDLE: begin
        if (io_malu.valid) begin
          w_state = ST_RUN;
          w_count = '0;
          w_acc   = '0;
          w_arg_0 = '0;
          w_arg_1 = '0;
        end
      end
      ST_RUN: begin
        w_acc   = io_malu.n_acc;
        w_arg_0 = io_malu.n_arg_0;
        w_arg_1 = io_malu.n_arg_1;
        w_count = (r_count == CNT_MAX) ? r_count : r_count + CW'(1);
        if (io_malu.dp_ready) w_state = ST_DONE;
      end
      ST_DONE: begin
        if (!io_malu.valid) w_state = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase
    if (io_malu.flush) begin
      w_state = ST_IDLE;
      w_count = '0;
      w_acc   = '0;
      w_arg_0 = '0;
      w_arg_1 = '0;
    end
    w_busy  = (w_state == ST_RUN);
    w_ready = (w_state == ST_DONE);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_acc   <= '0;
      r_arg_0 <= '0;
      r_arg_1 <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state;
      r_count <= w_count;
      r_acc   <= w_acc;
      r_arg_0 <= w_arg_0;
      r_arg_1 <= w_arg_1;
      r_busy  <= w_busy;
      r_ready <= w_ready;
    end
  end

  // Element LSB positions for the selected packed width; none selected means 32.
  always_comb begin
    w_bnd = 32'h0000_0001;
    if (io_malu.pw_32)      w_bnd = 32'h0000_0001;
    else if (io_malu.pw_16) w_bnd = 32'h0001_0001;
    else if (io_malu.pw_8)  w_bnd = 32'h0101_0101;
    else if (io_malu.pw_4)  w_bnd = 32'h1111_1111;
    else if (io_malu.pw_2)  w_bnd = 32'h5555_5555;
  end

  // Ripple chain broken at element boundaries, or everywhere when cen is low.
  always_comb begin
    w_rhs_e   = io_malu.padd_rhs ^ {32{io_malu.padd_sub}};
    w_sum     = '0;
    w_cout    = '0;
    w_carry   = 1'b0;
    w_cin_bit = 1'b0;
    for (int i = 0; i < 32; i++) begin
      w_cin_bit = w_bnd[i] ? (io_malu.padd_cin | io_malu.padd_sub)
                           : (io_malu.padd_cen & w_carry);
      w_sum[i]  = io_malu.padd_lhs[i] ^ w_rhs_e[i] ^ w_cin_bit;
      w_cout[i] = (io_malu.padd_lhs[i] & w_rhs_e[i]) |
                  (io_malu.padd_lhs[i] & w_cin_bit)  |
                  (w_rhs_e[i] & w_cin_bit);
      w_carry   = w_cout[i];
    end
  end

  assign io_malu.padd_result = w_sum;
  assign io_malu.padd_cout   = w_cout;
  assign io_malu.count       = r_count;
  assign io_malu.acc         = r_acc;
  assign io_malu.arg_0       = r_arg_0;
  assign io_malu.arg_1       = r_arg_1;
  assign io_malu.busy        = r_busy;
  assign io_malu.ready       = r_ready;

endmodule
